// File: rtl/adc_capture_trig.sv
// Sample-clock capture engine: decimated, triggered writes into a circular buffer held in an
// external dual-port RAM, with programmable pre-trigger depth and rising/falling/immediate trigger.
module adc_capture_trig #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [7:0]        decim,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] start_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] adc_q_reg;
  logic [1:0]        mode_reg;
  logic [DATA_W-1:0] level_reg;
  logic [7:0]        decim_reg;
  logic [ADDR_W-1:0] pretrig_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [7:0]        dcnt_reg;
  logic [ADDR_W-1:0] pre_cnt_reg;
  logic [ADDR_W-1:0] post_left_reg;
  logic [DATA_W-1:0] prev_reg;
  logic              prev_valid_reg;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [ADDR_W-1:0] trig_addr_reg;
  logic [ADDR_W-1:0] start_addr_reg;

  logic              active;
  logic              strobe;
  logic              rise_hit;
  logic              fall_hit;
  logic              trig_hit;
  logic [ADDR_W-1:0] post_init;

  // pretrig is ADDR_W bits wide, so it can never exceed DEPTH-1: the clamp is implicit.
  always_comb begin
    active    = (state_reg == S_PRE) || (state_reg == S_WAIT) || (state_reg == S_POST);
    strobe    = active && (dcnt_reg == 8'd0) && !arm && !abort;
    rise_hit  = prev_valid_reg && (prev_reg < level_reg) && (adc_q_reg >= level_reg);
    fall_hit  = prev_valid_reg && (prev_reg > level_reg) && (adc_q_reg <= level_reg);
    post_init = {ADDR_W{1'b1}} - pretrig_reg;
    case (mode_reg)
      2'b01:   trig_hit = rise_hit;
      2'b10:   trig_hit = fall_hit;
      default: trig_hit = 1'b1;
    endcase

    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else if (arm) begin
      state_next = (pretrig == '0) ? S_WAIT : S_PRE;
    end else if (strobe) begin
      case (state_reg)
        S_PRE: begin
          if (pre_cnt_reg + 1'b1 == pretrig_reg) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (trig_hit) state_next = (post_init == '0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (post_left_reg == ADDR_W'(1)) state_next = S_DONE;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      adc_q_reg      <= '0;
      mode_reg       <= '0;
      level_reg      <= '0;
      decim_reg      <= '0;
      pretrig_reg    <= '0;
      ptr_reg        <= '0;
      dcnt_reg       <= '0;
      pre_cnt_reg    <= '0;
      post_left_reg  <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      trig_addr_reg  <= '0;
      start_addr_reg <= '0;
    end else begin
      adc_q_reg <= adc_data;
      wr_en_reg <= strobe;
      if (strobe) begin
        wr_addr_reg <= ptr_reg;
        wr_data_reg <= adc_q_reg;
      end

      if (arm && !abort) begin
        mode_reg       <= trig_mode;
        level_reg      <= trig_level;
        decim_reg      <= decim;
        pretrig_reg    <= pretrig;
        ptr_reg        <= '0;
        dcnt_reg       <= '0;
        pre_cnt_reg    <= '0;
        prev_valid_reg <= 1'b0;
      end else if (active && !abort) begin
        dcnt_reg <= (dcnt_reg == decim_reg) ? 8'd0 : dcnt_reg + 8'd1;
        if (strobe) begin
          ptr_reg        <= ptr_reg + 1'b1;
          prev_reg       <= adc_q_reg;
          prev_valid_reg <= 1'b1;
          if (state_reg == S_PRE)
            pre_cnt_reg <= (state_next == S_PRE) ? pre_cnt_reg + 1'b1 : '0;
          if (state_reg == S_WAIT && trig_hit) begin
            trig_addr_reg  <= ptr_reg;
            start_addr_reg <= ptr_reg - pretrig_reg;
            post_left_reg  <= post_init;
          end
          if (state_reg == S_POST)
            post_left_reg <= post_left_reg - 1'b1;
        end
      end
    end
  end

  assign wr_en      = wr_en_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign busy       = active;
  assign done       = (state_reg == S_DONE);
  assign trig_addr  = trig_addr_reg;
  assign start_addr = start_addr_reg;

endmodule

// File: tb/tb_adc_capture_trig.sv
// Directed bench for adc_capture_trig with a 16-entry buffer: table of capture scenarios
// plus hand-written sequences for decimation timing, abort, pretrig clamp and async reset.
`timescale 1ns/1ps
module tb_adc_capture_trig;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] adc_data;
  logic          arm;
  logic          abort;
  logic [1:0]    trig_mode;
  logic [DW-1:0] trig_level;
  logic [AW-1:0] pretrig;
  logic [7:0]    decim;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  adc_capture_trig #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .adc_data(adc_data), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_level(trig_level), .pretrig(pretrig), .decim(decim),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .trig_addr(trig_addr), .start_addr(start_addr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Shadow of the external RAM, filled from the write port mid-cycle.
  logic [7:0] mem [DEPTH];
  int wr_cnt = 0;
  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  int g_base;
  int g_fall;
  int idx;

  // Stimulus sample k (k=0 is the value presented during the arm cycle).
  function automatic logic [7:0] gen(int k);
    if (g_fall != 0) return (k < g_fall) ? 8'hFF : 8'h00;
    return 8'(g_base + k);
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idx++;
    adc_data = gen(idx);
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [7:0] lvl, input logic [3:0] pre,
                        input logic [7:0] dec, input int base, input int fall);
    trig_mode  = m;
    trig_level = lvl;
    pretrig    = pre;
    decim      = dec;
    g_base     = base;
    g_fall     = fall;
    idx        = 0;
    adc_data   = gen(0);
    arm        = 1'b1;
    @(posedge clk);
    #1;
    arm      = 1'b0;
    idx      = 1;
    adc_data = gen(1);
  endtask

  task automatic run_to_done(input string name);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    chk({name, "_reach_done"}, int'(done), 1);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] level;
    logic [3:0] pre;
    logic [7:0] dec;
    int base;
    int fall;
    int e_trig;
    int e_start;
    int e_writes;
    int e_old;
    int e_new;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int w0;
    int st;
    int prev_done;

    //            mode   level  pre  dec  base  fall trig start writes old   new
    vecs[0] = '{2'b00, 8'h00, 4'd0,  8'd0, 0,    0,   0,   0,    16,  8'h00, 8'h0F};
    vecs[1] = '{2'b01, 8'h80, 4'd4,  8'd0, 'h70, 0,   0,   12,   28,  8'h7C, 8'h8B};
    vecs[2] = '{2'b10, 8'h40, 4'd4,  8'd0, 0,    40,  8,   4,    52,  8'hFF, 8'h00};
    vecs[3] = '{2'b11, 8'h00, 4'd0,  8'd3, 0,    0,   0,   0,    16,  8'h00, 8'h3C};
    vecs[4] = '{2'b01, 8'h80, 4'd0,  8'd1, 'h70, 0,   8,   8,    24,  8'h80, 8'h9E};
    vecs[5] = '{2'b10, 8'h40, 4'd15, 8'd0, 0,    20,  4,   5,    21,  8'hFF, 8'h00};

    resetn = 1'b0; arm = 1'b0; abort = 1'b0; adc_data = '0;
    trig_mode = '0; trig_level = '0; pretrig = '0; decim = '0;
    g_base = 0; g_fall = 0; idx = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_trig_addr", int'(trig_addr), 0);
    chk("rst_start_addr", int'(start_addr), 0);
    resetn = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      w0 = wr_cnt;
      do_arm(vecs[v].mode, vecs[v].level, vecs[v].pre, vecs[v].dec, vecs[v].base, vecs[v].fall);
      run_to_done($sformatf("vec%0d", v));
      tick();
      tick();
      st = vecs[v].e_start;
      chk($sformatf("vec%0d_trig_addr", v), int'(trig_addr), vecs[v].e_trig);
      chk($sformatf("vec%0d_start_addr", v), int'(start_addr), st);
      chk($sformatf("vec%0d_writes", v), wr_cnt - w0, vecs[v].e_writes);
      chk($sformatf("vec%0d_oldest", v), int'(mem[st]), vecs[v].e_old);
      chk($sformatf("vec%0d_newest", v), int'(mem[(st + DEPTH - 1) % DEPTH]), vecs[v].e_new);
      $display("[TB] vec%0d mode=%0d pre=%0d dec=%0d trig_addr=%0d start_addr=%0d writes=%0d",
               v, vecs[v].mode, vecs[v].pre, vecs[v].dec, trig_addr, start_addr, wr_cnt - w0);
    end

    // Decimation by 4: wr_en exactly every 4th cycle, data every 4th ramp value.
    do_arm(2'b00, 8'h00, 4'd0, 8'd3, 'h10, 0);
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk($sformatf("decim_wr_en_c%0d", j), int'(wr_en), int'(j % 4 == 1));
      if (j % 4 == 1) chk($sformatf("decim_wr_data_c%0d", j), int'(wr_data), 'h10 + j - 1);
    end
    run_to_done("decim");
    $display("[TB] decim sequence: trig_addr=%0d", trig_addr);

    // Pretrig at maximum: POST skipped, done shows with the trigger write.
    do_arm(2'b00, 8'h00, 4'hF, 8'd0, 0, 0);
    w0 = wr_cnt;
    prev_done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      prev_done = int'(done);
      tick();
    end
    chk("clamp_done", int'(done), 1);
    chk("clamp_done_prev", prev_done, 0);
    chk("clamp_wr_en_at_done", int'(wr_en), 1);
    chk("clamp_wr_addr_at_done", int'(wr_addr), 15);
    chk("clamp_wr_data_at_done", int'(wr_data), 15);
    chk("clamp_trig_addr", int'(trig_addr), 15);
    chk("clamp_start_addr", int'(start_addr), 0);
    tick();
    tick();
    chk("clamp_writes", wr_cnt - w0, 16);
    $display("[TB] clamp sequence: trig_addr=%0d start_addr=%0d", trig_addr, start_addr);

    // Async reset pulse in the middle of PRE.
    do_arm(2'b00, 8'h00, 4'hF, 8'd0, 0, 0);
    repeat (5) tick();
    chk("midpre_busy", int'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("areset_wr_en", int'(wr_en), 0);
    chk("areset_wr_addr", int'(wr_addr), 0);
    chk("areset_wr_data", int'(wr_data), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_done", int'(done), 0);
    chk("areset_trig_addr", int'(trig_addr), 0);
    chk("areset_start_addr", int'(start_addr), 0);
    #2 resetn = 1'b1;
    w0 = wr_cnt;
    repeat (5) tick();
    chk("areset_no_writes", wr_cnt - w0, 0);
    chk("areset_idle", int'(busy), 0);
    $display("[TB] async reset sequence done");

    // Abort while waiting for a trigger, then a clean re-arm.
    do_arm(2'b01, 8'h80, 4'd2, 8'd0, 0, 0);
    repeat (10) tick();
    chk("abort_busy_before", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_wr_en", int'(wr_en), 0);
    w0 = wr_cnt;
    repeat (5) tick();
    chk("abort_no_writes", wr_cnt - w0, 0);
    w0 = wr_cnt;
    do_arm(2'b00, 8'h00, 4'd0, 8'd0, 'h20, 0);
    run_to_done("rearm");
    tick();
    tick();
    chk("rearm_trig_addr", int'(trig_addr), 0);
    chk("rearm_mem0", int'(mem[0]), 'h20);
    chk("rearm_mem15", int'(mem[15]), 'h2F);
    chk("rearm_writes", wr_cnt - w0, 16);
    $display("[TB] abort/re-arm sequence: writes=%0d", wr_cnt - w0);

    // arm and abort together: abort wins.
    arm = 1'b1;
    abort = 1'b1;
    tick();
    arm = 1'b0;
    abort = 1'b0;
    chk("armabort_busy", int'(busy), 0);
    chk("armabort_done", int'(done), 0);
    w0 = wr_cnt;
    repeat (4) tick();
    chk("armabort_no_writes", wr_cnt - w0, 0);
    chk("armabort_still_idle", int'(busy), 0);
    $display("[TB] arm+abort sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
